// File: rtl/board_ctrl.sv
// board_ctrl: synchronised, debounced button channels with rise/fall strobes, stretched system reset and single-step strobe.
//   clk      : single clock
//   rst_n    : asynchronous active-low reset
//   btn_in   : raw asynchronous buttons [N]
//   btn_lvl  : debounced levels [N]; btn_rise/btn_fall : one-cycle edge strobes [N]
//   sys_rst  : active-high system reset, stretched RST_LEN cycles, held while btn RST_BTN is down
//   step     : one-cycle step strobe from btn STEP_BTN
//   Define BOARD_CTRL_REPEAT_EN to auto-repeat step while the step button is held.
module board_ctrl #(
   parameter int N             = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int DEBOUNCE_LEN  = 32,
   parameter int RST_LEN       = 16,
   parameter int RST_BTN       = 0,
   parameter int STEP_BTN      = 2,
   parameter int REPEAT_DELAY  = 1000000,
   parameter int REPEAT_PERIOD = 250000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] btn_in,
   output logic [N-1:0] btn_lvl,
   output logic [N-1:0] btn_rise,
   output logic [N-1:0] btn_fall,
   output logic         sys_rst,
   output logic         step
);
   localparam int DW = $clog2(DEBOUNCE_LEN + 1);
   localparam int RW = $clog2(RST_LEN + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_LEN - 1);
   localparam logic [DW-1:0] DB_ONE  = DW'(1);
   localparam logic [RW-1:0] RC_FULL = RW'(RST_LEN);
   localparam logic [RW-1:0] RC_ONE  = RW'(1);
   if (SYNC_STAGES < 2 || DEBOUNCE_LEN < 1 || RST_LEN < 1 || RST_BTN >= N || STEP_BTN >= N ||
       RST_BTN == STEP_BTN || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("board_ctrl: illegal parameter combination");
   end
   logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
   logic [N-1:0][DW-1:0]          cnt_q, cnt_d;
   logic [N-1:0]                  lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d, tog, s;
   logic [RW-1:0]                 rc_q, rc_d;
   logic                          step_q, step_d, fire;
   assign sys_rst  = (rc_q != '0);
   assign btn_lvl  = lvl_q;
   assign btn_rise = rise_q;
   assign btn_fall = fall_q;
   assign step     = step_q;
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
      s      = sync_q[SYNC_STAGES-1];
      tog    = '0;
      cnt_d  = '0;
      for (int i = 0; i < N; i++) begin
         // the DEBOUNCE_LEN-th disagreeing sample accepts the change
         tog[i]   = (s[i] != lvl_q[i]) && (cnt_q[i] == DB_LAST);
         cnt_d[i] = (s[i] == lvl_q[i] || tog[i]) ? '0 : cnt_q[i] + DB_ONE;
      end
      lvl_d  = lvl_q ^ tog;
      rise_d = tog & ~lvl_q;
      fall_d = tog & lvl_q;
      rc_d   = lvl_q[RST_BTN] ? RC_FULL : (rc_q != '0) ? rc_q - RC_ONE : '0;
      // presses landing inside a system reset are dropped, not queued
      step_d = (rise_q[STEP_BTN] & ~sys_rst) | fire;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         lvl_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         rc_q   <= RC_FULL;
         step_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         rc_q   <= rc_d;
         step_q <= step_d;
      end
   end
`ifdef BOARD_CTRL_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int PW   = $clog2(RMAX + 1);
   logic [PW-1:0] rep_q, rep_d;
   logic          rpt_q, rpt_d, hold;
   // rep_q counts cycles since the level rose (or since the last repeat); rpt_q marks the first repeat done
   always_comb begin
      hold  = lvl_q[STEP_BTN] & ~sys_rst;
      // a release landing on the repeat cycle suppresses that strobe
      fire  = hold & lvl_d[STEP_BTN] & (rep_q == (rpt_q ? PW'(REPEAT_PERIOD) : PW'(REPEAT_DELAY)));
      rep_d = !hold ? '0 : fire ? PW'(1) : rep_q + PW'(1);
      rpt_d = hold & (rpt_q | fire);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
         rpt_q <= 1'b0;
      end else begin
         rep_q <= rep_d;
         rpt_q <= rpt_d;
      end
   end
`else
   assign fire = 1'b0;
`endif
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed vector bench for board_ctrl (N=4, SYNC_STAGES=2, DEBOUNCE_LEN=8, RST_LEN=16).
module tb_board_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_in = '0;
   logic [3:0] btn_lvl, btn_rise, btn_fall;
   logic       sys_rst, step;
   int         tests = 0;
   int         errors = 0;

   typedef struct {
      logic [3:0] btn;
      int         n;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       srst;
      logic       stp;
   } vec_t;
   vec_t vt[16];

`ifdef BOARD_CTRL_REPEAT_EN
   localparam int EXP_STEPS = 5;
`else
   localparam int EXP_STEPS = 1;
`endif

   always #5 clk = ~clk;

   board_ctrl #(
      .N(4), .SYNC_STAGES(2), .DEBOUNCE_LEN(8), .RST_LEN(16), .RST_BTN(0), .STEP_BTN(2),
      .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_lvl(btn_lvl), .btn_rise(btn_rise),
      .btn_fall(btn_fall), .sys_rst(sys_rst), .step(step)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int bad, early, cnt, first;
      vt[0]  = '{4'b0010, 9,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[1]  = '{4'b0010, 1,  4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0};
      vt[2]  = '{4'b0010, 1,  4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[3]  = '{4'b0000, 9,  4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[4]  = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0};
      vt[5]  = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[6]  = '{4'b1010, 9,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[7]  = '{4'b1010, 1,  4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0};
      vt[8]  = '{4'b0000, 9,  4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[9]  = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b0};
      vt[10] = '{4'b0100, 10, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0};
      vt[11] = '{4'b0100, 1,  4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1};
      vt[12] = '{4'b0100, 1,  4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[13] = '{4'b0000, 9,  4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[14] = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0};
      vt[15] = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

      // reset state and stretch after rst_n release
      tick(3);
      chk("rst_lvl", 32'(btn_lvl), 0);
      chk("rst_strobes", 32'({btn_rise, btn_fall, step}), 0);
      chk("rst_sys_rst", 32'(sys_rst), 1);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (sys_rst !== 1'b1) bad++;
      end
      chk("stretch_hold", 32'(bad), 0);
      tick(1);
      chk("stretch_fall", 32'(sys_rst), 0);
      chk("stretch_others", 32'({btn_lvl, btn_rise, btn_fall, step}), 0);

      // table-driven clean presses, simultaneous channels, single step
      for (int i = 0; i < 16; i++) begin
         btn_in = vt[i].btn;
         tick(vt[i].n);
         chk($sformatf("vec%0d_lvl", i),  32'(btn_lvl),  32'(vt[i].lvl));
         chk($sformatf("vec%0d_rise", i), 32'(btn_rise), 32'(vt[i].rise));
         chk($sformatf("vec%0d_fall", i), 32'(btn_fall), 32'(vt[i].fall));
         chk($sformatf("vec%0d_srst", i), 32'(sys_rst),  32'(vt[i].srst));
         chk($sformatf("vec%0d_step", i), 32'(step),     32'(vt[i].stp));
      end

      // bounce rejection: 7 high / 3 low x5, then a held press
      bad = 0;
      for (int r = 0; r < 5; r++) begin
         btn_in = 4'b0010;
         for (int t = 0; t < 7; t++) begin
            tick(1);
            if (btn_rise[1] || btn_lvl[1]) bad++;
         end
         btn_in = 4'b0000;
         for (int t = 0; t < 3; t++) begin
            tick(1);
            if (btn_rise[1] || btn_lvl[1]) bad++;
         end
      end
      chk("bounce_quiet", 32'(bad), 0);
      btn_in = 4'b0010;
      early = 0;
      for (int t = 1; t < 10; t++) begin
         tick(1);
         if (btn_lvl[1] || btn_rise[1]) early++;
      end
      chk("bounce_early", 32'(early), 0);
      tick(1);
      chk("bounce_rise", 32'(btn_rise), 32'(4'b0010));
      btn_in = 4'b0000;
      tick(12);
      chk("bounce_idle", 32'(btn_lvl), 0);

      // step count over a long hold
      btn_in = 4'b0100;
      tick(10);
      chk("hold_rise", 32'(btn_rise[2]), 1);
      cnt = 0;
      first = 0;
      for (int t = 1; t <= 40; t++) begin
         tick(1);
         if (step) begin
            cnt++;
            if (first == 0) first = t;
         end
      end
      chk("hold_first_step", 32'(first), 1);
      chk("hold_step_count", 32'(cnt), 32'(EXP_STEPS));
      btn_in = 4'b0000;
      tick(12);

      // reset button: sys_rst held, step suppressed, then stretched release
      btn_in = 4'b0001;
      tick(10);
      chk("rbtn_rise", 32'(btn_rise), 32'(4'b0001));
      chk("rbtn_srst_pre", 32'(sys_rst), 0);
      tick(1);
      chk("rbtn_srst_on", 32'(sys_rst), 1);
      btn_in = 4'b0101;
      bad = 0;
      cnt = 0;
      for (int t = 0; t < 89; t++) begin
         tick(1);
         if (sys_rst !== 1'b1) bad++;
         if (step) cnt++;
      end
      chk("rbtn_srst_held", 32'(bad), 0);
      chk("rbtn_step_blocked", 32'(cnt), 0);
      chk("rbtn_lvl2", 32'(btn_lvl), 32'(4'b0101));
      btn_in = 4'b0100;
      tick(10);
      chk("rbtn_fall", 32'(btn_fall), 32'(4'b0001));
      bad = 0;
      for (int t = 0; t < 15; t++) begin
         tick(1);
         if (sys_rst !== 1'b1) bad++;
         if (step) cnt++;
      end
      chk("rbtn_stretch", 32'(bad), 0);
      tick(1);
      chk("rbtn_srst_off", 32'(sys_rst), 0);
      for (int t = 0; t < 8; t++) begin
         tick(1);
         if (step) cnt++;
      end
      chk("rbtn_no_queued_step", 32'(cnt), 0);
      btn_in = 4'b0000;
      tick(12);

      // async reset four cycles into a debounce
      btn_in = 4'b0010;
      tick(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_srst_async", 32'(sys_rst), 1);
      chk("arst_outs", 32'({btn_lvl, btn_rise, btn_fall, step}), 0);
      bad = 0;
      for (int t = 0; t < 20; t++) begin
         tick(1);
         if (btn_rise || btn_lvl || step) bad++;
      end
      chk("arst_quiet", 32'(bad), 0);
      rst_n = 1'b1;
      early = 0;
      for (int t = 1; t < 10; t++) begin
         tick(1);
         if (btn_lvl[1] || btn_rise[1]) early++;
      end
      chk("arst_fresh_early", 32'(early), 0);
      tick(1);
      chk("arst_fresh_rise", 32'(btn_rise), 32'(4'b0010));
      chk("arst_srst_still", 32'(sys_rst), 1);
      btn_in = 4'b0000;
      tick(12);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule

// File: doc/board_ctrl.md
# board_ctrl

Parametrised board-input conditioner for the FPGA top level. It replaces hand-built per-button sync/history logic with N synchronised, debounced button channels that each give a level plus one-cycle rise and fall strobes. It also provides a stretched system reset, re-armable from a designated button, and a single-step strobe generator feeding the CPU's `stepping`/`do_step` control.

## Interface
Parameters:
- `N`, 4: number of button channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_LEN`, 32: consecutive stable synchronised samples required to accept a change (≥1).
- `RST_LEN`, 16: `sys_rst` hold cycles after the reset source releases (≥1).
- `RST_BTN`, 0: channel index that requests a system reset.
- `STEP_BTN`, 2: channel index that generates step strobes. Must differ from `RST_BTN`; both must be < N.
- `REPEAT_DELAY`, 1000000: cycles from a step press to the first auto-repeat (≥1, macro only).
- `REPEAT_PERIOD`, 250000: cycles between subsequent auto-repeats (≥1, macro only).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_in` in N: raw, asynchronous button inputs.
- `btn_lvl` out N: debounced level.
- `btn_rise` out N: one-cycle strobe when `btn_lvl` goes 0→1.
- `btn_fall` out N: one-cycle strobe when `btn_lvl` goes 1→0.
- `sys_rst` out 1: active-high, synchronous-deassert system reset.
- `step` out 1: one-cycle step strobe.

## Operation
- **Synchroniser.** Each channel passes through a `SYNC_STAGES` flop chain. The last stage is the sample `s[i]`.
- **Debounce counter.** Each channel has a counter of width clog2(DEBOUNCE_LEN+1).
  - If `s[i]==btn_lvl[i]`: the counter clears.
  - Otherwise it increments.
  - On the edge where it would reach `DEBOUNCE_LEN`: `btn_lvl[i]` toggles, the counter clears, and `btn_rise[i]` or `btn_fall[i]` is registered high for exactly that cycle.
  - Any single agreeing sample restarts the count.
- **Reset stretcher.** A counter `rc` of width clog2(RST_LEN+1), with `sys_rst = (rc != 0)`.
  - While `btn_lvl[RST_BTN]`=1, `rc` reloads to `RST_LEN`.
  - Otherwise `rc` decrements to 0 and saturates.
  - `rst_n` low forces `rc=RST_LEN` asynchronously.
- **Step generator.**
  - `step` = registered `btn_rise[STEP_BTN] & ~sys_rst`.
  - Strobes that would fall while `sys_rst`=1 are dropped, not queued.
- **Channel independence.** All channels are independent. Simultaneous changes on several channels produce simultaneous strobes.

## Timing
- **Reset values:**
  - `btn_lvl`, `btn_rise`, `btn_fall`, `step`: 0.
  - `sys_rst`: 1.
  - Sync chains and debounce counters: 0.
- **Input latency.** An input change set up before edge k and held produces `btn_lvl`/strobe at edge k + SYNC_STAGES + DEBOUNCE_LEN − 1.
- **Step latency.** `step` asserts 1 cycle after `btn_rise[STEP_BTN]`.
- **`sys_rst` after `rst_n` release.** `sys_rst` stays high for exactly `RST_LEN` rising edges after `rst_n` deasserts, then falls.
- **`sys_rst` after reset-button release.** `sys_rst` falls exactly `RST_LEN` cycles after the `btn_fall[RST_BTN]` cycle.
- **Button held through reset.** The channel is seen as a fresh press. `btn_rise` fires after the full input latency. For `RST_BTN`, `sys_rst` therefore never drops in between.
- **Mid-operation reset.** `rst_n` asserted mid-debounce or mid-repeat aborts all state immediately. No strobe may be emitted in the cycle of, or after, reset assertion.
- **Strobe width.** Strobes are never wider than 1 cycle. Back-to-back toggles on one channel are ≥ DEBOUNCE_LEN cycles apart.

## Configuration
- `BOARD_CTRL_REPEAT_EN` defined:
  - While `btn_lvl[STEP_BTN]`=1 and `sys_rst`=0, a repeat counter produces extra `step` strobes.
  - The first repeat comes `REPEAT_DELAY` cycles after the initial strobe, then one every `REPEAT_PERIOD` cycles.
  - The counter clears on release, on `sys_rst`, or on `rst_n`.
  - A release at the exact repeat cycle suppresses that strobe.
- Undefined: exactly one `step` per press. The `REPEAT_*` parameters are ignored and no repeat counter is synthesised.

## Test plan
- **Reset stretch.** N=4, RST_LEN=16: pulse `rst_n` low → `sys_rst`=1 throughout, falls on the 16th edge after release. All other outputs 0.
- **Clean press.** DEBOUNCE_LEN=8, SYNC_STAGES=2, `btn_in[1]` 0→1 held → `btn_lvl[1]`=1 and `btn_rise[1]`=1 for one cycle at edge k+9. Release → `btn_fall[1]` one cycle at the same latency.
- **Bounce rejection.** Toggle `btn_in[1]` with highs of 7 cycles and lows of 3 cycles, 5 times, then hold high → no strobes during the bounce, then a single `btn_rise[1]` 9 cycles after the final hold begins.
- **Reset button.** Hold `btn_in[0]` for 100 cycles → `sys_rst` stays 1. `step` is suppressed even with `btn_in[2]` pressed. `sys_rst` falls 16 cycles after `btn_fall[0]`.
- **Step and repeat.** With the macro, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold `btn_in[2]` for 40 cycles after `btn_lvl` rises → 5 `step` strobes at offsets +1, +21, +26, +31, +36. Without the macro → 1 strobe.
- **Async reset mid-debounce.** Assert `rst_n` 4 cycles into a debounce → counters clear, no strobe. `sys_rst`=1 immediately and asynchronously.
